window_fetch_3x3: RTL

- Downstream consumer of frame_buffer.
- On a start request, issues nine sequential reads around a centre pixel through the frame buffer's read port and assembles a complete 3x3 neighbourhood.
- Presents the window with a one-cycle valid pulse to the edge-detection (Sobel) stage.
- Handles edges: row wrap-around (ring of P_ROWS line buffers) and column clamping (edge replication).

---
 rtl/window_fetch_3x3_if.sv | 33 +++
 rtl/window_fetch_3x3.sv | 135 +++++++++++++
 2 files changed

// File: rtl/window_fetch_3x3_if.sv
// Signal bundle between window_fetch_3x3, its frame-buffer read port and the Sobel stage.
// I_START is a request taken only while O_BUSY is low; O_VALID is a one-cycle completion pulse with no back-pressure.
interface window_fetch_3x3_if #(
  parameter int P_COLUMNS     = 640,
  parameter int P_ROWS        = 4,
  parameter int P_PIXEL_DEPTH = 24
);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_ROWS);

  logic                       I_ENABLE;
  logic                       I_START;
  logic [CW-1:0]              I_CENTER_COL;
  logic [RW-1:0]              I_CENTER_ROW;
  logic [P_PIXEL_DEPTH-1:0]   I_FB_PIXEL;
  logic [CW-1:0]              O_FB_COL;
  logic [RW-1:0]              O_FB_ROW;
  logic                       O_FB_READ_ENABLE;
  logic [9*P_PIXEL_DEPTH-1:0] O_WINDOW;
  logic                       O_VALID;
  logic                       O_BUSY;
  logic [1:0]                 O_DBG_STATE;

  modport slave (
    input  I_ENABLE, I_START, I_CENTER_COL, I_CENTER_ROW, I_FB_PIXEL,
    output O_FB_COL, O_FB_ROW, O_FB_READ_ENABLE, O_WINDOW, O_VALID, O_BUSY, O_DBG_STATE
  );

  modport master (
    output I_ENABLE, I_START, I_CENTER_COL, I_CENTER_ROW, I_FB_PIXEL,
    input  O_FB_COL, O_FB_ROW, O_FB_READ_ENABLE, O_WINDOW, O_VALID, O_BUSY, O_DBG_STATE
  );
endinterface

// File: rtl/window_fetch_3x3.sv
// Fetches a 3x3 neighbourhood from the frame buffer with nine sequential reads,
// wrapping rows around the line-buffer ring and replicating edge columns.
module window_fetch_3x3 #(
  parameter int P_COLUMNS     = 640,
  parameter int P_ROWS        = 4,
  parameter int P_PIXEL_DEPTH = 24
) (
  input logic               I_CLK,
  input logic               I_RESET,
  window_fetch_3x3_if.slave bus
);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_ROWS);
  localparam int PD = P_PIXEL_DEPTH;
  localparam int WW = 9 * PD;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [CW-1:0]   cc_q, cc_d;
  logic [RW-1:0]   cr_q, cr_d;
  logic            re_q, re_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            pend_q, pend_d;
  logic [3:0]      pidx_q, pidx_d;
  logic [WW-1:0]   win_q, win_d;

  // Element k sits at column offset (k mod 3) - 1; edges replicate the border pixel.
  function automatic logic [CW-1:0] col_of(input logic [CW-1:0] c, input logic [3:0] k);
    logic [CW-1:0] r;
    r = c;
    case (k)
      4'd0, 4'd3, 4'd6: if (c != '0) r = c - CW'(1);
      4'd2, 4'd5, 4'd8: if (c != CW'(P_COLUMNS - 1)) r = c + CW'(1);
      default: r = c;
    endcase
    return r;
  endfunction

  // Element k sits at row offset (k div 3) - 1, wrapping around the ring.
  function automatic logic [RW-1:0] row_of(input logic [RW-1:0] rr, input logic [3:0] k);
    logic [RW-1:0] r;
    r = rr;
    case (k)
      4'd0, 4'd1, 4'd2: r = (rr == '0) ? RW'(P_ROWS - 1) : rr - RW'(1);
      4'd6, 4'd7, 4'd8: r = (rr == RW'(P_ROWS - 1)) ? '0 : rr + RW'(1);
      default: r = rr;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cc_d    = cc_q;
    cr_d    = cr_q;
    re_d    = re_q;
    col_d   = col_q;
    row_d   = row_q;
    pend_d  = pend_q;
    pidx_d  = pidx_q;
    win_d   = win_q;
    if (bus.I_ENABLE) begin
      pend_d = 1'b0;
      for (int i = 0; i < 9; i++) begin
        if (pend_q && pidx_q == 4'(i)) win_d[i*PD +: PD] = bus.I_FB_PIXEL;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.I_START) begin
            cc_d    = bus.I_CENTER_COL;
            cr_d    = bus.I_CENTER_ROW;
            k_d     = 4'd0;
            re_d    = 1'b1;
            col_d   = col_of(bus.I_CENTER_COL, 4'd0);
            row_d   = row_of(bus.I_CENTER_ROW, 4'd0);
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          pend_d = 1'b1;
          pidx_d = k_q;
          if (k_q == 4'd8) begin
            re_d    = 1'b0;
            state_d = S_DRAIN;
          end else begin
            k_d   = k_q + 4'd1;
            col_d = col_of(cc_q, k_q + 4'd1);
            row_d = row_of(cr_q, k_q + 4'd1);
          end
        end
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cc_q    <= '0;
      cr_q    <= '0;
      re_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      pend_q  <= 1'b0;
      pidx_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cc_q    <= cc_d;
      cr_q    <= cr_d;
      re_q    <= re_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
      win_q   <= win_d;
    end
  end

  // A stall gates the read strobe so the frame buffer keeps the pixel still owed to us.
  assign bus.O_FB_READ_ENABLE = re_q & bus.I_ENABLE;
  assign bus.O_FB_COL         = col_q;
  assign bus.O_FB_ROW         = row_q;
  assign bus.O_WINDOW         = win_q;
  assign bus.O_VALID          = (state_q == S_DONE);
  assign bus.O_BUSY           = (state_q != S_IDLE);
  assign bus.O_DBG_STATE      = state_q;
endmodule
